exe_muldiv_unit: RTL
====================

Name: exe_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EXE stage.
- Consumes the operand and control outputs of the ID/EXE pipeline register and runs a one-bit-per-cycle shift-add multiply or restoring divide.
- Raises busy_o so hazard control freezes the ID/EXE register and upstream stages until the result is ready.
- Delivers the result with a one-cycle done_o pulse toward the EXE/MEM path.

Parameters:
XLEN, 32, operand/result width; iteration count per operation
CNT_W, 6, width of iteration counter (must satisfy 2^CNT_W > XLEN)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
start_i  input  1  request from ID/EXE; op_i, dataA_i, dataB_i valid this cycle
op_i  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
dataA_i  input  XLEN  rs1 operand (multiplicand / dividend)
dataB_i  input  XLEN  rs2 operand (multiplier / divisor)
flush_i  input  1  synchronous abort (branch/exception flush)
busy_o  output  1  operation in progress; stall request to hazard control
done_o  output  1  one-cycle pulse; result_o valid
result_o  output  XLEN  result; held stable until next accepted start

Behaviour:
- Reset (rst low, any state, including mid-operation): state IDLE, busy_o=0, done_o=0, result_o=0, counter and datapath registers 0. Takes effect immediately, no clock required.
- States: IDLE, MUL, DIV, DONE.
- IDLE, start accept:
  - Accept when start_i=1 and flush_i=0; the accept edge is E0.
  - Latch op. For signed ops (MULH: both operands; MULHSU: A only; DIV/REM: both), latch operand magnitudes plus a result-sign flag.
  - Counter cleared to 0. Next state MUL (op<4) or DIV (op>=4).
- Division special cases, detected at E0:
  - Divide by zero (B=0): quotient all-ones, remainder = dataA_i.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF, DIV/REM): quotient 0x80000000, remainder 0.
  - Go directly to DONE. done_o is high in the cycle after E0.
- MUL datapath:
  - 2*XLEN-bit accumulator. Each edge: if multiplier LSB is 1, add multiplicand to the upper half, then shift right by 1; counter+1.
  - Leave after counter reaches XLEN-1, i.e. XLEN iterations.
- DIV datapath:
  - Restoring division. Each edge: shift the {remainder, quotient} pair left by 1; trial-subtract the divisor; if non-negative, keep the difference and set the quotient LSB.
  - XLEN iterations.
- Final edge (E0+XLEN):
  - Apply sign correction by two's-complement negation. The quotient/product takes the result-sign flag. The remainder takes the dividend's sign.
  - Select output: MUL = low XLEN bits; MULH/MULHSU/MULHU = high XLEN bits; DIV/DIVU = quotient; REM/REMU = remainder.
  - Write result_o and enter DONE.
- Timing, normal ops:
  - busy_o=1 from after E0 through the edge E0+XLEN.
  - done_o=1 for exactly one cycle after E0+XLEN. Total latency is XLEN+1 cycles from the accept cycle to the done cycle.
- DONE: busy_o=0, done_o=1 for one cycle, then IDLE unconditionally.
  - start_i in DONE is ignored; ID/EXE keeps it asserted until the stage advances.
- start_i while in MUL/DIV: ignored; operands are not re-sampled.
- flush_i:
  - In MUL/DIV/DONE: next state IDLE, busy_o=0, done_o=0, result_o unchanged.
  - In IDLE: blocks acceptance.
  - flush_i has priority over start_i.
- Stall contract: upstream registers are frozen while busy_o=1. This block does not rely on operand stability after E0.
- All arithmetic is modulo 2^XLEN. Negating 0x80000000 yields 0x80000000 and is not an error.

Test Plan:
- Reset, then MUL 7 x 6 -> busy_o high 32 cycles, done_o single pulse at cycle 33 after accept, result_o=0x0000002A, held until next start.
- Upper-half multiplies, one op each:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
  - MUL 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000001.
- Signed divide, A=0xFFFFFFF9 (-7), B=2:
  - DIV -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases, each with done_o in the cycle after accept and busy_o never high:
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Flush and start handling:
  - Start MUL, assert flush_i at iteration 10 -> next cycle IDLE, busy_o=0, no done_o, result_o keeps prior value.
  - Second start_i pulsed mid-operation -> ignored, first result correct.
  - start_i held high through DONE -> exactly one done_o, no re-issue.
- Drop rst asynchronously (between clock edges) at iteration 20 of DIV -> busy_o, done_o, result_o go to 0 immediately. After release, a new DIVU 9/3 -> 3.

Source files
------------

// File: rtl/exe_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EXE stage: one-bit-per-cycle
// shift-add multiply and restoring divide, with a stall request while it runs.
module exe_muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] dataA_i,
   input  logic [XLEN-1:0] dataB_i,
   input  logic            flush_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [XLEN-1:0] ZERO_X = {XLEN{1'b0}};
   localparam logic [XLEN-1:0] ONES_X = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] MIN_X  = {1'b1, {(XLEN-1){1'b0}}};

   function automatic logic [XLEN-1:0] f_neg(input logic [XLEN-1:0] v);
      return (~v) + {{(XLEN-1){1'b0}}, 1'b1};
   endfunction

   function automatic logic [2*XLEN-1:0] f_neg2(input logic [2*XLEN-1:0] v);
      return (~v) + {{(2*XLEN-1){1'b0}}, 1'b1};
   endfunction

   state_t              r_state;
   state_t              w_state_nxt;
   logic [2:0]          r_op;
   logic [CNT_W-1:0]    r_cnt;
   logic [2*XLEN-1:0]   r_acc;
   logic [XLEN-1:0]     r_opb;
   logic                r_neg_res;
   logic                r_neg_rem;
   logic [XLEN-1:0]     r_result;

   logic                w_accept;
   logic                w_last;
   logic                w_a_signed;
   logic                w_b_signed;
   logic                w_a_neg;
   logic                w_b_neg;
   logic [XLEN-1:0]     w_a_mag;
   logic [XLEN-1:0]     w_b_mag;
   logic                w_div0;
   logic                w_ovf;
   logic [XLEN:0]       w_mul_add;
   logic [XLEN:0]       w_mul_sum;
   logic [2*XLEN-1:0]   w_mul_nxt;
   logic [XLEN:0]       w_rem_sh;
   logic [XLEN:0]       w_trial;
   logic                w_ge;
   logic [2*XLEN-1:0]   w_div_nxt;
   logic [2*XLEN-1:0]   w_prod;
   logic [XLEN-1:0]     w_quo;
   logic [XLEN-1:0]     w_rem;
   logic [XLEN-1:0]     w_final;

   assign w_accept = start_i & ~flush_i;
   assign w_last   = (r_cnt == CNT_W'(XLEN-1));

   // Operand signedness, magnitudes and division special-case detection at accept
   always_comb begin
      w_a_signed = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
      w_b_signed = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
      w_a_neg    = w_a_signed & dataA_i[XLEN-1];
      w_b_neg    = w_b_signed & dataB_i[XLEN-1];
      w_a_mag    = w_a_neg ? f_neg(dataA_i) : dataA_i;
      w_b_mag    = w_b_neg ? f_neg(dataB_i) : dataB_i;
      w_div0     = op_i[2] && (dataB_i == ZERO_X);
      w_ovf      = op_i[2] && !op_i[0] && (dataA_i == MIN_X) && (dataB_i == ONES_X);
   end

   // One iteration of each datapath plus sign correction and result selection
   always_comb begin
      w_mul_add = r_acc[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}};
      w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + w_mul_add;
      w_mul_nxt = {w_mul_sum, r_acc[XLEN-1:1]};
      // remainder needs XLEN+1 bits after the shift when the divisor MSB is set
      w_rem_sh  = r_acc[2*XLEN-1:XLEN-1];
      w_trial   = w_rem_sh - {1'b0, r_opb};
      w_ge      = ~w_trial[XLEN];
      w_div_nxt = {(w_ge ? w_trial[XLEN-1:0] : w_rem_sh[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};
      w_prod    = r_neg_res ? f_neg2(w_mul_nxt) : w_mul_nxt;
      w_quo     = r_neg_res ? f_neg(w_div_nxt[XLEN-1:0]) : w_div_nxt[XLEN-1:0];
      w_rem     = r_neg_rem ? f_neg(w_div_nxt[2*XLEN-1:XLEN]) : w_div_nxt[2*XLEN-1:XLEN];
      case (r_op)
         3'd0:                 w_final = w_prod[XLEN-1:0];
         3'd1, 3'd2, 3'd3:     w_final = w_prod[2*XLEN-1:XLEN];
         3'd4, 3'd5:           w_final = w_quo;
         3'd6, 3'd7:           w_final = w_rem;
         default:              w_final = ZERO_X;
      endcase
   end

   // Next-state logic; flush always returns to IDLE
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_div0 || w_ovf) begin
                  w_state_nxt = S_DONE;
               end else if (op_i[2]) begin
                  w_state_nxt = S_DIV;
               end else begin
                  w_state_nxt = S_MUL;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_MUL, S_DIV: begin
            if (flush_i) begin
               w_state_nxt = S_IDLE;
            end else if (w_last) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = r_state;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Operand latch, iteration and result registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_op      <= 3'd0;
         r_cnt     <= {CNT_W{1'b0}};
         r_acc     <= {(2*XLEN){1'b0}};
         r_opb     <= ZERO_X;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_result  <= ZERO_X;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op      <= op_i;
                  r_cnt     <= {CNT_W{1'b0}};
                  r_neg_res <= w_a_neg ^ w_b_neg;
                  r_neg_rem <= w_a_neg;
                  if (op_i[2]) begin
                     r_acc <= {ZERO_X, w_a_mag};
                     r_opb <= w_b_mag;
                  end else begin
                     r_acc <= {ZERO_X, w_b_mag};
                     r_opb <= w_a_mag;
                  end
                  if (w_div0) begin
                     r_result <= op_i[1] ? dataA_i : ONES_X;
                  end else if (w_ovf) begin
                     r_result <= op_i[1] ? ZERO_X : MIN_X;
                  end
               end
            end
            S_MUL, S_DIV: begin
               if (!flush_i) begin
                  r_acc <= (r_state == S_MUL) ? w_mul_nxt : w_div_nxt;
                  r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                  if (w_last) begin
                     r_result <= w_final;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy_o   = (r_state == S_MUL) || (r_state == S_DIV);
   assign done_o   = (r_state == S_DONE);
   assign result_o = r_result;

endmodule
